vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
// - Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.
// - Derives the pixel rate from the system clock via a clock-enable divider (no generated clock).
// - Emits pixel coordinates, line/frame strobes and polarity-configurable syncs.
// - Sync/blank can be delayed PIPE_LAT pixel ticks to align with a pipelined video generator.
// PARAMETERS
// - CLK_DIV     2    system clocks per pixel; legal 1..16 (1 => pix_tick always high)
// - H_ACTIVE    640  visible pixels per line
// - H_FP        16   horizontal front porch, pixels
// - H_SYNC      96   horizontal sync width, pixels
// - H_BP        48   horizontal back porch, pixels
// - V_ACTIVE    480  visible lines per frame
// - V_FP        10   vertical front porch, lines
// - V_SYNC      2    vertical sync width, lines
// - V_BP        33   vertical back porch, lines
// - HSYNC_POL   0    0: hsync active-low, 1: active-high
// - VSYNC_POL   0    0: vsync active-low, 1: active-high
// - PIPE_LAT    0    pixel-tick delay of hsync/vsync/blank_b vs x/y; legal 0..7
// - CW          11   coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
// PORTS
// - clk          in   1   system clock
// - reset_n      in   1   asynchronous active-low reset
// - en           in   1   run enable; low freezes divider and counters
// - pix_tick     out  1   one-clk pulse per pixel; all pixel-rate state advances on it
// - x            out  CW  current pixel column (hcnt), 0..H_TOTAL-1
// - y            out  CW  current line (vcnt), 0..V_TOTAL-1
// - active       out  1   undelayed: x<H_ACTIVE && y<V_ACTIVE
// - line_start   out  1   pix_tick && x==0
// - frame_start  out  1   pix_tick && x==0 && y==0
// - hsync        out  1   horizontal sync, polarity per HSYNC_POL, delayed PIPE_LAT ticks
// - vsync        out  1   vertical sync, polarity per VSYNC_POL, delayed PIPE_LAT ticks
// - blank_b      out  1   1 = visible pixel, delayed PIPE_LAT ticks
// - sync_b       out  1   constant 0 (composite sync unused)
// - frame_cnt    out  FRAME_CNT_W  frame counter (only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
// - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults: 800 x 525.
// - Reset (async assert, sync release): div=0, x=0, y=0, pix_tick=0, delay line flushed.
//   Outputs: hsync=vsync=inactive level, blank_b=0, active=1, strobes=0.
// - Divider: div counts 0..CLK_DIV-1 while en=1; pix_tick=1 when div==CLK_DIV-1.
//   With CLK_DIV=2, first pix_tick is on the 2nd clk edge after reset release.
// - Counters (on pix_tick): x==H_TOTAL-1 -> x=0, y+=1; y==V_TOTAL-1 at that point -> y=0.
//   No value >= H_TOTAL/V_TOTAL is ever produced.
// - Raw sync: hs_raw = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs_raw = y in
//   [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). Polarity: out = POL ? raw : ~raw.
// - Delay line: {hs,vs,active} shift register clocked on pix_tick, PIPE_LAT deep.
//   PIPE_LAT=0 -> combinational pass-through of registered x/y.
// - en low: pix_tick=0, all state held, outputs static; resume continues exactly where it stopped.
// - Reset mid-frame: immediate return to reset values; next frame begins at x=0, y=0.
// CONFIGURATION
// - VGA_FRAME_CNT_EN defined: adds parameter FRAME_CNT_W (default 16) and port frame_cnt.
//   frame_cnt resets to 0, increments on the clk with frame_start=1 (i.e. when the x=0, y=0
//   pixel is issued), wraps modulo 2^FRAME_CNT_W. The very first frame after reset also counts.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset: hold reset_n=0 -> hsync=1, vsync=1, blank_b=0, x=0, y=0. Release with en=1 ->
//   pix_tick every 2nd clk.
// - Line timing (defaults): hsync low for exactly 96 ticks starting at x=656.
//   line_start period = 800 ticks = 1600 clk.
// - Frame timing: vsync low for lines 490-491 only. blank_b=1 only for x<640, y<480.
//   frame_start every 420000 ticks = 840000 clk. y wraps 524 -> 0.
// - PIPE_LAT=3: hsync/blank_b edges lag the undelayed position by 3 ticks
//   (hsync falls at x=659, blank_b falls at x=643).
// - en=0 at x=300 for 50 clk: x, y, hsync, blank_b frozen and pix_tick=0; next tick gives x=301.
//   Then assert reset_n=0 at y=200 -> all outputs to reset values asynchronously.
// - VGA_FRAME_CNT_EN, FRAME_CNT_W=2: frame_cnt goes 1, 2, 3, 0 across four frame_start pulses.
//   CLK_DIV=1: pix_tick held at 1.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle driven by vga_timing_gen. Carries frame_cnt only when
// VGA_FRAME_CNT_EN is defined.
`timescale 1ns/1ps
interface vga_timing_gen_if #(
  parameter int CW = 11
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_CNT_W = 16
`endif
);
  logic          pix_tick;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  logic          sync_b;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;
`endif

  modport master (
    output pix_tick, x, y, active, line_start, frame_start,
           hsync, vsync, blank_b, sync_b
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input pix_tick, x, y, active, line_start, frame_start,
          hsync, vsync, blank_b, sync_b
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with clock-enable pixel divider and
// optional sync/blank delay line. VGA_FRAME_CNT_EN adds a frame counter.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIPE_LAT  = 0,
  parameter int CW        = 11
`ifdef VGA_FRAME_CNT_EN
  , parameter int FRAME_CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  vga_timing_gen_if.master  vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          run_q;
  logic          tick;
  logic          hs_raw, vs_raw, act_raw;
  logic          hs_dl, vs_dl, act_dl;

  // run_q keeps pix_tick low in the first cycle after reset release, so
  // CLK_DIV=1 does not tick while reset is held and blank_b stays 0 in reset.
  assign tick = en & run_q & (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      run_q <= 1'b1;
    end
  end

  assign hs_raw  = (x_q >= CW'(HS_BEG)) && (x_q < CW'(HS_END));
  assign vs_raw  = (y_q >= CW'(VS_BEG)) && (y_q < CW'(VS_END));
  assign act_raw = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));

  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign hs_dl  = hs_raw;
      assign vs_dl  = vs_raw;
      assign act_dl = act_raw & run_q;
    end else begin : g_dly
      logic [2:0] dl_q [PIPE_LAT];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
        end else if (tick) begin
          dl_q[0] <= {hs_raw, vs_raw, act_raw};
          for (int unsigned i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end

      assign {hs_dl, vs_dl, act_dl} = dl_q[PIPE_LAT-1];
    end
  endgenerate

  assign vid.pix_tick    = tick;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.active      = act_raw;
  assign vid.line_start  = tick && (x_q == '0);
  assign vid.frame_start = tick && (x_q == '0) && (y_q == '0);
  assign vid.hsync       = (HSYNC_POL != 0) ? hs_dl : ~hs_dl;
  assign vid.vsync       = (VSYNC_POL != 0) ? vs_dl : ~vs_dl;
  assign vid.blank_b     = act_dl;
  assign vid.sync_b      = 1'b0;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] fcnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
    end else if (tick && (x_q == '0) && (y_q == '0)) begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign vid.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: two small-raster instances checked every
// cycle against a tick-count model of the raster.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 15
  localparam int VT = VA + VF + VS + VB;   // 11
  localparam int FT = HT * VT;             // 165
  localparam int CW = 6;
  localparam int FCW = 2;
  localparam int DIV_A = 2, LAT_A = 0, HPOL_A = 0, VPOL_A = 0;
  localparam int DIV_B = 1, LAT_B = 3, HPOL_B = 1, VPOL_B = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic en = 1'b0;
  bit   chk_on = 1'b1;

  int tests = 0;
  int fails = 0;

  // model state: edges since release, enabled edges since release, ticks per instance
  int rel = 0, ne = 0, ta = 0, tb = 0;

  always #5 clk = ~clk;

`ifdef VGA_FRAME_CNT_EN
  vga_timing_gen_if #(.CW(CW), .FRAME_CNT_W(FCW)) vif_a ();
  vga_timing_gen_if #(.CW(CW), .FRAME_CNT_W(FCW)) vif_b ();
`else
  vga_timing_gen_if #(.CW(CW)) vif_a ();
  vga_timing_gen_if #(.CW(CW)) vif_b ();
`endif

  vga_timing_gen #(
    .CLK_DIV(DIV_A), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL_A), .VSYNC_POL(VPOL_A), .PIPE_LAT(LAT_A), .CW(CW)
`ifdef VGA_FRAME_CNT_EN
    , .FRAME_CNT_W(FCW)
`endif
  ) dut_a (.clk(clk), .reset_n(reset_n), .en(en), .vid(vif_a));

  vga_timing_gen #(
    .CLK_DIV(DIV_B), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HPOL_B), .VSYNC_POL(VPOL_B), .PIPE_LAT(LAT_B), .CW(CW)
`ifdef VGA_FRAME_CNT_EN
    , .FRAME_CNT_W(FCW)
`endif
  ) dut_b (.clk(clk), .reset_n(reset_n), .en(en), .vid(vif_b));

  function automatic bit exp_tick(int div);
    return reset_n && (rel >= 1) && en && ((ne % div) == (div - 1));
  endfunction

  function automatic bit hraw(int t);
    int x;
    x = t % HT;
    return (x >= HA + HF) && (x < HA + HF + HS);
  endfunction

  function automatic bit vraw(int t);
    int y;
    y = (t / HT) % VT;
    return (y >= VA + VF) && (y < VA + VF + VS);
  endfunction

  function automatic bit araw(int t);
    return ((t % HT) < HA) && (((t / HT) % VT) < VA);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel = 0; ne = 0; ta = 0; tb = 0;
    end else begin
      if (exp_tick(DIV_A)) ta++;
      if (exp_tick(DIV_B)) tb++;
      if (en) ne++;
      rel++;
    end
  end

  task automatic chk1(input string name, input logic act, input bit exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input logic [31:0] act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input string tag, input int t, input int div, input int lat,
                          input int hpol, input int vpol,
                          input logic pt, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input logic act, input logic ls, input logic fs,
                          input logic hs, input logic vs, input logic bb, input logic sb);
    bit tk, dh, dv, da;
    tk = exp_tick(div);
    dh = (t >= lat) ? hraw(t - lat) : 1'b0;
    dv = (t >= lat) ? vraw(t - lat) : 1'b0;
    da = (t >= lat) ? araw(t - lat) : 1'b0;
    chk1({tag, ".pix_tick"}, pt, tk);
    chkn({tag, ".x"}, {{(32-CW){1'b0}}, x}, t % HT);
    chkn({tag, ".y"}, {{(32-CW){1'b0}}, y}, (t / HT) % VT);
    chk1({tag, ".active"}, act, araw(t));
    chk1({tag, ".line_start"}, ls, tk && ((t % HT) == 0));
    chk1({tag, ".frame_start"}, fs, tk && ((t % FT) == 0));
    chk1({tag, ".hsync"}, hs, (hpol != 0) ? dh : ~dh);
    chk1({tag, ".vsync"}, vs, (vpol != 0) ? dv : ~dv);
    chk1({tag, ".blank_b"}, bb, da && (rel >= 1));
    chk1({tag, ".sync_b"}, sb, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk_inst("A", ta, DIV_A, LAT_A, HPOL_A, VPOL_A, vif_a.pix_tick, vif_a.x, vif_a.y,
               vif_a.active, vif_a.line_start, vif_a.frame_start,
               vif_a.hsync, vif_a.vsync, vif_a.blank_b, vif_a.sync_b);
      chk_inst("B", tb, DIV_B, LAT_B, HPOL_B, VPOL_B, vif_b.pix_tick, vif_b.x, vif_b.y,
               vif_b.active, vif_b.line_start, vif_b.frame_start,
               vif_b.hsync, vif_b.vsync, vif_b.blank_b, vif_b.sync_b);
`ifdef VGA_FRAME_CNT_EN
      chkn("A.frame_cnt", {{(32-FCW){1'b0}}, vif_a.frame_cnt}, ((ta + FT - 1) / FT) % (1 << FCW));
      chkn("B.frame_cnt", {{(32-FCW){1'b0}}, vif_b.frame_cnt}, ((tb + FT - 1) / FT) % (1 << FCW));
`endif
    end
  end

  // Asserts reset asynchronously, checks the literal reset values, then releases.
  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    #1;
    chk1("rst.A.pix_tick", vif_a.pix_tick, 1'b0);
    chkn("rst.A.x", {{(32-CW){1'b0}}, vif_a.x}, 0);
    chkn("rst.A.y", {{(32-CW){1'b0}}, vif_a.y}, 0);
    chk1("rst.A.hsync", vif_a.hsync, 1'b1);
    chk1("rst.A.vsync", vif_a.vsync, 1'b1);
    chk1("rst.A.blank_b", vif_a.blank_b, 1'b0);
    chk1("rst.A.active", vif_a.active, 1'b1);
    chk1("rst.B.pix_tick", vif_b.pix_tick, 1'b0);
    chk1("rst.B.hsync", vif_b.hsync, 1'b0);
    chk1("rst.B.vsync", vif_b.vsync, 1'b0);
    chk1("rst.B.blank_b", vif_b.blank_b, 1'b0);
    repeat (hold) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int r;
    // model pins (hsync pixels 10..12, vsync lines 7..8, visible 8x6)
    chk1("pin.hraw9", hraw(9), 1'b0);
    chk1("pin.hraw10", hraw(10), 1'b1);
    chk1("pin.hraw12", hraw(12), 1'b1);
    chk1("pin.hraw13", hraw(13), 1'b0);
    chk1("pin.vraw7", vraw(7 * HT + 4), 1'b1);
    chk1("pin.vraw9", vraw(9 * HT), 1'b0);
    chk1("pin.araw", araw(5 * HT + 7), 1'b1);
    chk1("pin.araw_y6", araw(6 * HT), 1'b0);

    #1;
    en = 1'b1;
    do_reset(3);

    // 20 edges after release: A ticked 10 times, B ticked 19 times
    repeat (20) @(posedge clk);
    #2;
    chkn("lit.A.x", {{(32-CW){1'b0}}, vif_a.x}, 10);
    chkn("lit.A.y", {{(32-CW){1'b0}}, vif_a.y}, 0);
    chk1("lit.A.hsync", vif_a.hsync, 1'b0);
    chk1("lit.A.blank_b", vif_a.blank_b, 1'b0);
    chk1("lit.A.pix_tick", vif_a.pix_tick, 1'b0);
    chkn("lit.B.x", {{(32-CW){1'b0}}, vif_b.x}, 4);
    chkn("lit.B.y", {{(32-CW){1'b0}}, vif_b.y}, 1);
    chk1("lit.B.hsync", vif_b.hsync, 1'b0);
    chk1("lit.B.blank_b", vif_b.blank_b, 1'b1);
    chk1("lit.B.pix_tick", vif_b.pix_tick, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    chkn("lit.A.frame_cnt", {{(32-FCW){1'b0}}, vif_a.frame_cnt}, 1);
`endif

    // freeze for 50 clocks, then an uninterrupted run across several frames
    en = 1'b0;
    repeat (50) @(posedge clk);
    #2 en = 1'b1;
    repeat (1500) @(posedge clk);

    for (int i = 0; i < 12000; i++) begin
      @(posedge clk);
      #2;
      r = $urandom_range(0, 1999);
      if (r == 0) begin
        do_reset($urandom_range(1, 4));
      end else if (r < 12) begin
        en = 1'b0;
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #2 en = 1'b1;
      end else begin
        en = ($urandom_range(0, 7) != 0);
      end
    end

    @(posedge clk);
    #2 chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
